// File: rtl/instr_streamer_if.sv
`default_nettype none
// ============================================================
// instr_streamer_if : host/CPU-side signal bundle for instr_streamer
// Revision 1.0
// ============================================================
interface instr_streamer_if #(
  parameter int AW = 4
);
  logic          WrEn;
  logic [31:0]   WrData;
  logic          Clear;
  logic          Start;
  logic [AW:0]   Count;
  logic          Full;
  logic          Busy;
  logic          Done;
  logic          CpuReset;
  logic          LoadInstructions;
  logic [31:0]   Instruction;

  modport master (
    output WrEn, WrData, Clear, Start,
    input  Count, Full, Busy, Done, CpuReset, LoadInstructions, Instruction
  );

  modport slave (
    input  WrEn, WrData, Clear, Start,
    output Count, Full, Busy, Done, CpuReset, LoadInstructions, Instruction
  );
endinterface
`default_nettype wire

// File: rtl/instr_streamer.sv
`default_nettype none
// ============================================================
// instr_streamer : buffers a program, then resets/loads/launches a CPU
// Revision 1.0
// ============================================================
module instr_streamer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  wire logic         clk,
  input  wire logic         Reset,
  instr_streamer_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLR    = 3'd1,
    LOAD   = 3'd2,
    LAUNCH = 3'd3,
    FIN    = 3'd4
  } state_t;

  localparam logic [AW:0] c_full_count = (AW+1)'(DEPTH);

  logic [31:0]   r_mem [DEPTH];
  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_rd, w_rd_nxt;
  logic [AW:0]   r_count, w_count_nxt;
  logic          r_full, r_busy, r_done, r_cpu_reset, r_load;
  logic [31:0]   r_instr;
  logic          w_wr;

  always_comb begin
    w_state_nxt = r_state;
    w_rd_nxt    = r_rd;
    w_count_nxt = r_count;
    w_wr        = 1'b0;
    case (r_state)
      IDLE: begin
        // Start (when accepted) outranks Clear, which outranks WrEn
        if (bus.Start && (r_count != '0)) begin
          w_state_nxt = CLR;
          w_rd_nxt    = '0;
        end else if (bus.Clear) begin
          w_count_nxt = '0;
        end else if (bus.WrEn && !r_full) begin
          w_wr        = 1'b1;
          w_count_nxt = r_count + 1'b1;
        end
      end
      CLR: begin
        w_state_nxt = LOAD;
        w_rd_nxt    = '0;
      end
      LOAD: begin
        if ({1'b0, r_rd} == (r_count - 1'b1))
          w_state_nxt = LAUNCH;
        else
          w_rd_nxt = r_rd + 1'b1;
      end
      LAUNCH:  w_state_nxt = FIN;
      FIN:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_state     <= IDLE;
      r_rd        <= '0;
      r_count     <= '0;
      r_full      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cpu_reset <= 1'b0;
      r_load      <= 1'b0;
      r_instr     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_rd        <= w_rd_nxt;
      r_count     <= w_count_nxt;
      r_full      <= (w_count_nxt == c_full_count);
      r_busy      <= (w_state_nxt == CLR) || (w_state_nxt == LOAD) || (w_state_nxt == LAUNCH);
      r_done      <= (w_state_nxt == FIN);
      r_cpu_reset <= (w_state_nxt == CLR) || (w_state_nxt == LAUNCH);
      r_load      <= (w_state_nxt == LOAD);
      r_instr     <= (w_state_nxt == LOAD) ? r_mem[w_rd_nxt] : 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr)
      r_mem[r_count[AW-1:0]] <= bus.WrData;
  end

  assign bus.Count            = r_count;
  assign bus.Full             = r_full;
  assign bus.Busy             = r_busy;
  assign bus.Done             = r_done;
  assign bus.CpuReset         = r_cpu_reset;
  assign bus.LoadInstructions = r_load;
  assign bus.Instruction      = r_instr;

endmodule
`default_nettype wire

// File: tb/tb_instr_streamer.sv
`default_nettype none
// ============================================================
// tb_instr_streamer : directed self-checking bench for instr_streamer
// Revision 1.0
// ============================================================
module tb_instr_streamer;

  logic clk = 1'b0;
  logic Reset;
  always #5 clk = ~clk;

  instr_streamer_if #(.AW(4)) bus();

  instr_streamer #(.DEPTH(16), .AW(4)) dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [31:0] exp_words [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.WrEn   = 1'b0;
    bus.WrData = 32'd0;
    bus.Clear  = 1'b0;
    bus.Start  = 1'b0;
  endtask

  task automatic write_word(input logic [31:0] d);
    bus.WrEn   = 1'b1;
    bus.WrData = d;
    tick();
    bus.WrEn   = 1'b0;
  endtask

  // Start a sequence of n words and check every cycle against exp_words.
  // With disturb set, WrEn/Clear/Start are pulsed during the first LOAD cycle.
  task automatic play(input int n, input bit disturb);
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    chk("clr_cpureset", bus.CpuReset, 1);
    chk("clr_busy", bus.Busy, 1);
    chk("clr_load", bus.LoadInstructions, 0);
    chk("clr_instr", bus.Instruction, 0);
    for (int i = 0; i < n; i++) begin
      tick();
      chk($sformatf("load%0d_load", i), bus.LoadInstructions, 1);
      chk($sformatf("load%0d_instr", i), bus.Instruction, exp_words[i]);
      chk($sformatf("load%0d_cpureset", i), bus.CpuReset, 0);
      if (disturb && i == 0) begin
        bus.WrEn   = 1'b1;
        bus.WrData = 32'hDEADBEEF;
        bus.Clear  = 1'b1;
        bus.Start  = 1'b1;
      end else begin
        drive_idle();
      end
    end
    tick();
    chk("launch_cpureset", bus.CpuReset, 1);
    chk("launch_load", bus.LoadInstructions, 0);
    chk("launch_instr", bus.Instruction, 0);
    chk("launch_done", bus.Done, 0);
    tick();
    chk("fin_done", bus.Done, 1);
    chk("fin_busy", bus.Busy, 0);
    chk("fin_cpureset", bus.CpuReset, 0);
    tick();
    chk("idle_done", bus.Done, 0);
    chk("idle_count", bus.Count, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset = 1'b0;
    drive_idle();
    #12;
    chk("rst_count", bus.Count, 0);
    chk("rst_full", bus.Full, 0);
    chk("rst_busy", bus.Busy, 0);
    chk("rst_done", bus.Done, 0);
    chk("rst_cpureset", bus.CpuReset, 0);
    chk("rst_load", bus.LoadInstructions, 0);
    chk("rst_instr", bus.Instruction, 0);
    @(negedge clk);
    Reset = 1'b1;
    tick();

    // Three-word program, Done five edges after Start
    exp_words[0] = 32'h200101A7;
    exp_words[1] = 32'h2002005C;
    exp_words[2] = 32'h2003000D;
    for (int i = 0; i < 3; i++) write_word(exp_words[i]);
    chk("w3_count", bus.Count, 3);
    chk("w3_full", bus.Full, 0);
    play(3, 1'b0);

    // Inputs during LOAD are ignored, then a replay gives the same stream
    play(3, 1'b1);
    play(3, 1'b0);

    // Start with an empty buffer does nothing
    bus.Clear = 1'b1;
    tick();
    bus.Clear = 1'b0;
    chk("clear_count", bus.Count, 0);
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    chk("empty_busy", bus.Busy, 0);
    chk("empty_cpureset", bus.CpuReset, 0);
    chk("empty_load", bus.LoadInstructions, 0);
    tick();
    chk("empty_busy2", bus.Busy, 0);
    chk("empty_cpureset2", bus.CpuReset, 0);

    // Fill to DEPTH, then a 17th write is dropped
    for (int i = 0; i < 16; i++) begin
      exp_words[i] = 32'hA5000000 | (i * 32'h00010101);
      write_word(exp_words[i]);
    end
    chk("fill_count", bus.Count, 16);
    chk("fill_full", bus.Full, 1);
    write_word(32'hBAD0BAD0);
    chk("over_count", bus.Count, 16);
    chk("over_full", bus.Full, 1);
    play(16, 1'b0);
    chk("after16_full", bus.Full, 1);

    // Clear wins over a simultaneous WrEn
    bus.Clear = 1'b1;
    tick();
    bus.Clear = 1'b0;
    for (int i = 0; i < 5; i++) write_word(32'h11110000 + i);
    chk("w5_count", bus.Count, 5);
    chk("w5_full", bus.Full, 0);
    bus.Clear  = 1'b1;
    bus.WrEn   = 1'b1;
    bus.WrData = 32'h77777777;
    tick();
    drive_idle();
    chk("clrwr_count", bus.Count, 0);

    // Asynchronous reset in the second LOAD cycle of a 4-word program
    exp_words[0] = 32'hC0DE0001;
    exp_words[1] = 32'hC0DE0002;
    exp_words[2] = 32'hC0DE0003;
    exp_words[3] = 32'hC0DE0004;
    for (int i = 0; i < 4; i++) write_word(exp_words[i]);
    chk("w4_count", bus.Count, 4);
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    tick();
    chk("ab_load0_instr", bus.Instruction, exp_words[0]);
    tick();
    chk("ab_load1_instr", bus.Instruction, exp_words[1]);
    Reset = 1'b0;
    #1;
    chk("ab_load", bus.LoadInstructions, 0);
    chk("ab_cpureset", bus.CpuReset, 0);
    chk("ab_instr", bus.Instruction, 0);
    chk("ab_busy", bus.Busy, 0);
    chk("ab_done", bus.Done, 0);
    chk("ab_count", bus.Count, 0);
    tick();
    tick();
    chk("ab_held_done", bus.Done, 0);
    @(negedge clk);
    Reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("post_done%0d", i), bus.Done, 0);
      chk($sformatf("post_busy%0d", i), bus.Busy, 0);
    end
    chk("post_count", bus.Count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
